// File: rtl/sram_fetch_pkg.sv
// Shared types and constants for the SRAM fetch engine.
package sram_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam logic REGION_IMAGE = 1'b1;
  localparam logic REGION_COEF  = 1'b0;

  localparam int unsigned IDX_W = 8;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pipe_entry_t;

endpackage

// File: rtl/sram_fetch_engine_rd_latency_pipe.sv
// Read-latency shift register: carries {valid, idx} from issue to SRAM data return.
module rd_latency_pipe
  import sram_fetch_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             empty
);

  pipe_entry_t stage [RD_LAT];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_valid;
      stage[0].idx   <= in_valid ? in_idx : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_valid = stage[RD_LAT-1].valid;
  assign out_idx   = stage[RD_LAT-1].idx;

  // Looks only at stages behind the output stage: when they are clear the
  // pipe is empty after the next edge, so DONE lands right after the last write.
  always_comb begin
    empty = 1'b1;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/sram_fetch_engine.sv
// Streams an image block or the next coefficient set from SRAM into the weight buffer.
// Optional parity checking of returned words is enabled by defining SRAM_PARITY_EN.
module sram_fetch_engine
  import sram_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IMG_WORDS  = 64,
  parameter int unsigned COEF_WORDS = 16,
  parameter int unsigned COEF_SETS  = 8,
  parameter int unsigned IMG_BASE   = 'h0000,
  parameter int unsigned COEF_BASE  = 'h0100,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_sram,
  input  logic              n_coef_image,
  input  logic              coef_rewind,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              buf_wen,
  output logic [7:0]        buf_idx,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              busy,
  output logic              sram_done
`ifdef SRAM_PARITY_EN
  ,
  input  logic              sram_rpar,
  output logic              parity_err
`endif
);

  localparam int unsigned SET_W = (COEF_SETS > 1) ? $clog2(COEF_SETS) : 1;

  fetch_state_t      state;
  logic              region;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        issue_idx;
  logic [7:0]        last_idx;
  logic [SET_W-1:0]  coef_set;
  logic [SET_W-1:0]  eff_set;
  logic [ADDR_W-1:0] coef_base;
  logic              start_ok;
  logic              pipe_valid;
  logic [7:0]        pipe_idx;
  logic              pipe_empty;

  assign start_ok  = (state == IDLE) && start_sram;
  // A rewind coincident with start already applies to this fetch.
  assign eff_set   = coef_rewind ? '0 : coef_set;
  assign coef_base = ADDR_W'(COEF_BASE) + ADDR_W'(eff_set) * ADDR_W'(COEF_WORDS);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      region    <= REGION_COEF;
      addr      <= '0;
      issue_idx <= '0;
      last_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_sram) begin
            region    <= n_coef_image;
            issue_idx <= '0;
            if (n_coef_image == REGION_IMAGE) begin
              addr     <= ADDR_W'(IMG_BASE);
              last_idx <= 8'(IMG_WORDS - 1);
            end else begin
              addr     <= coef_base;
              last_idx <= 8'(COEF_WORDS - 1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          addr      <= addr + ADDR_W'(1);
          issue_idx <= issue_idx + 8'd1;
          if (issue_idx == last_idx) state <= DRAIN;
        end
        DRAIN: begin
          if (pipe_empty) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coef_set <= '0;
    end else if (coef_rewind) begin
      coef_set <= '0;
    end else if (state == DONE && region == REGION_COEF) begin
      coef_set <= (coef_set == SET_W'(COEF_SETS - 1)) ? '0 : coef_set + SET_W'(1);
    end
  end

  rd_latency_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (sram_ren),
    .in_idx    (issue_idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx),
    .empty     (pipe_empty)
  );

  assign sram_ren  = (state == ISSUE);
  assign sram_addr = sram_ren ? addr : '0;
  assign buf_wen   = pipe_valid;
  assign buf_idx   = pipe_idx;
  assign buf_wdata = buf_wen ? sram_rdata : '0;
  assign busy      = (state != IDLE);
  assign sram_done = (state == DONE);

`ifdef SRAM_PARITY_EN
  logic par_bad;
  logic par_sticky;

  assign par_bad = buf_wen && ((^sram_rdata) != sram_rpar);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_sticky <= 1'b0;
    end else if (start_ok) begin
      par_sticky <= 1'b0;
    end else if (par_bad) begin
      par_sticky <= 1'b1;
    end
  end

  // Flag is visible in the same cycle as the offending write.
  assign parity_err = par_sticky | par_bad;
`endif

endmodule

// File: tb/tb_sram_fetch_engine.sv
// Scoreboard bench for sram_fetch_engine with a latency-accurate SRAM model.
module tb_sram_fetch_engine;

  localparam int RD_LAT = 2;

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start_sram = 1'b0;
  logic        n_coef_image = 1'b0;
  logic        coef_rewind = 1'b0;
  logic        sram_ren;
  logic [15:0] sram_addr;
  logic [15:0] sram_rdata;
  logic        buf_wen;
  logic [7:0]  buf_idx;
  logic [15:0] buf_wdata;
  logic        busy;
  logic        sram_done;
`ifdef SRAM_PARITY_EN
  logic        sram_rpar;
  logic        parity_err;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] aq [$];
  wr_t         wq [$];

  logic        bad_en = 1'b0;
  logic [15:0] bad_addr = '0;

  logic [15:0] m_addr  [RD_LAT] = '{default: '0};
  logic        m_valid [RD_LAT] = '{default: 1'b0};

  always #5 clk = ~clk;

  function automatic logic [15:0] sram_word(input logic [15:0] a);
    return a ^ 16'hA5C3 ^ {a[7:0], a[15:8]};
  endfunction

  always @(posedge clk) begin
    m_addr[0]  <= sram_addr;
    m_valid[0] <= sram_ren;
    for (int k = 1; k < RD_LAT; k++) begin
      m_addr[k]  <= m_addr[k-1];
      m_valid[k] <= m_valid[k-1];
    end
  end

  assign sram_rdata = sram_word(m_addr[RD_LAT-1]);
`ifdef SRAM_PARITY_EN
  assign sram_rpar = (^sram_rdata) ^ (bad_en && m_valid[RD_LAT-1] && m_addr[RD_LAT-1] == bad_addr);
`endif

  sram_fetch_engine #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .IMG_WORDS  (64),
    .COEF_WORDS (16),
    .COEF_SETS  (8),
    .IMG_BASE   ('h0000),
    .COEF_BASE  ('h0100),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start_sram   (start_sram),
    .n_coef_image (n_coef_image),
    .coef_rewind  (coef_rewind),
    .sram_ren     (sram_ren),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .buf_wen      (buf_wen),
    .buf_idx      (buf_idx),
    .buf_wdata    (buf_wdata),
    .busy         (busy),
    .sram_done    (sram_done)
`ifdef SRAM_PARITY_EN
    ,
    .sram_rpar    (sram_rpar),
    .parity_err   (parity_err)
`endif
  );

  // One complete fetch, checked cycle by cycle from cycle 1 (first issue) onward.
  task automatic do_fetch(input string name, input logic region, input logic [15:0] base,
                          input int len, input int glitch_cyc, input int rewind_cyc,
                          input logic rewind_at_start, input int bad_idx);
    int   n_done;
    int   last;
    logic [15:0] ea;
    wr_t  ew;
    aq.delete();
    wq.delete();
    for (int i = 0; i < len; i++) begin
      aq.push_back(base + 16'(i));
      wq.push_back('{idx: 8'(i), data: sram_word(base + 16'(i))});
    end
    bad_en   = (bad_idx >= 0);
    bad_addr = base + 16'(bad_idx);
    n_done   = 0;
    last     = len + RD_LAT + 2;
    @(negedge clk);
    start_sram   = 1'b1;
    n_coef_image = region;
    coef_rewind  = rewind_at_start;
    @(negedge clk);
    start_sram  = 1'b0;
    coef_rewind = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      if (cyc > 1) @(negedge clk);
      checks++;
      if (sram_ren !== (cyc <= len)) begin
        failures++;
        $display("FAIL %s sram_ren cyc=%0d got=%b exp=%b", name, cyc, sram_ren, cyc <= len);
      end
      if (sram_ren === 1'b1) begin
        checks++;
        if (aq.size() == 0) begin
          failures++;
          $display("FAIL %s extra_issue cyc=%0d addr=%h exp=none", name, cyc, sram_addr);
        end else begin
          ea = aq.pop_front();
          if (sram_addr !== ea) begin
            failures++;
            $display("FAIL %s sram_addr cyc=%0d got=%h exp=%h", name, cyc, sram_addr, ea);
          end
        end
      end
      checks++;
      if (buf_wen !== (cyc > RD_LAT && cyc <= len + RD_LAT)) begin
        failures++;
        $display("FAIL %s buf_wen cyc=%0d got=%b exp=%b", name, cyc, buf_wen,
                 cyc > RD_LAT && cyc <= len + RD_LAT);
      end
      if (buf_wen === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL %s extra_write cyc=%0d idx=%0d exp=none", name, cyc, buf_idx);
        end else begin
          ew = wq.pop_front();
          if (buf_idx !== ew.idx || buf_wdata !== ew.data) begin
            failures++;
            $display("FAIL %s buf_write cyc=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                     name, cyc, buf_idx, buf_wdata, ew.idx, ew.data);
          end
        end
      end
      checks++;
      if (sram_done !== (cyc == len + RD_LAT + 1)) begin
        failures++;
        $display("FAIL %s sram_done cyc=%0d got=%b exp=%b", name, cyc, sram_done,
                 cyc == len + RD_LAT + 1);
      end
      if (sram_done === 1'b1) n_done++;
      checks++;
      if (busy !== (cyc <= len + RD_LAT + 1)) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, busy, cyc <= len + RD_LAT + 1);
      end
`ifdef SRAM_PARITY_EN
      checks++;
      if (parity_err !== ((bad_idx >= 0) && (cyc >= bad_idx + 1 + RD_LAT))) begin
        failures++;
        $display("FAIL %s parity_err cyc=%0d got=%b exp=%b", name, cyc, parity_err,
                 (bad_idx >= 0) && (cyc >= bad_idx + 1 + RD_LAT));
      end
`endif
      start_sram   = (cyc == glitch_cyc);
      n_coef_image = (cyc == glitch_cyc) ? ~region : region;
      coef_rewind  = (cyc == rewind_cyc);
    end
    start_sram  = 1'b0;
    coef_rewind = 1'b0;
    bad_en      = 1'b0;
    checks++;
    if (aq.size() != 0 || wq.size() != 0 || n_done != 1) begin
      failures++;
      $display("FAIL %s totals got missing_issue=%0d missing_write=%0d done=%0d exp 0 0 1",
               name, aq.size(), wq.size(), n_done);
    end
  endtask

  task automatic pulse_rewind();
    @(negedge clk);
    coef_rewind = 1'b1;
    @(negedge clk);
    coef_rewind = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_ren, sram_addr, buf_wen, buf_idx, buf_wdata, busy, sram_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ren=%b addr=%h wen=%b idx=%h wdata=%h busy=%b done=%b exp all 0",
               sram_ren, sram_addr, buf_wen, buf_idx, buf_wdata, busy, sram_done);
    end
`ifdef SRAM_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_parity got=%b exp=0", parity_err);
    end
`endif
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_image_fetch();
    do_fetch("image", 1'b1, 16'h0000, 64, 0, 0, 1'b0, -1);
  endtask

  task automatic test_coef_sets();
    do_fetch("coef_set0", 1'b0, 16'h0100, 16, 0, 0, 1'b0, -1);
    do_fetch("coef_set1", 1'b0, 16'h0110, 16, 0, 0, 1'b0, -1);
    do_fetch("coef_set2", 1'b0, 16'h0120, 16, 0, 0, 1'b0, -1);
  endtask

  task automatic test_coef_wrap();
    pulse_rewind();
    for (int s = 0; s < 9; s++) begin
      do_fetch("coef_wrap", 1'b0, 16'h0100 + 16'((s % 8) * 16), 16, 0, 0, 1'b0, -1);
    end
  endtask

  task automatic test_rewind();
    do_fetch("rw_at_done", 1'b0, 16'h0110, 16, 0, 16 + RD_LAT + 1, 1'b0, -1);
    do_fetch("rw_after_done", 1'b0, 16'h0100, 16, 0, 0, 1'b0, -1);
    do_fetch("rw_at_start", 1'b0, 16'h0100, 16, 0, 0, 1'b1, -1);
    do_fetch("rw_follow", 1'b0, 16'h0110, 16, 0, 0, 1'b0, -1);
    do_fetch("rw_pre_idle", 1'b0, 16'h0120, 16, 0, 0, 1'b0, -1);
    pulse_rewind();
    do_fetch("rw_idle", 1'b0, 16'h0100, 16, 0, 0, 1'b0, -1);
  endtask

  task automatic test_start_while_busy();
    do_fetch("busy_img_issue", 1'b1, 16'h0000, 64, 5, 0, 1'b0, -1);
    do_fetch("busy_coef_issue", 1'b0, 16'h0110, 16, 3, 0, 1'b0, -1);
    do_fetch("busy_coef_drain", 1'b0, 16'h0120, 16, 17, 0, 1'b0, -1);
    do_fetch("busy_img_done", 1'b1, 16'h0000, 64, 64 + RD_LAT + 1, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    start_sram   = 1'b1;
    n_coef_image = 1'b1;
    @(negedge clk);
    start_sram = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (sram_ren !== 1'b1 || sram_addr !== 16'h0008) begin
      failures++;
      $display("FAIL midreset_pre got ren=%b addr=%h exp ren=1 addr=0008", sram_ren, sram_addr);
    end
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if ({sram_ren, sram_addr, buf_wen, buf_idx, buf_wdata, busy, sram_done} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got ren=%b addr=%h wen=%b idx=%h wdata=%h busy=%b done=%b exp all 0",
               sram_ren, sram_addr, buf_wen, buf_idx, buf_wdata, busy, sram_done);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      checks++;
      if (sram_done !== 1'b0 || busy !== 1'b0 || buf_wen !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet c=%0d got done=%b busy=%b wen=%b exp 0 0 0",
                 c, sram_done, busy, buf_wen);
      end
    end
    do_fetch("after_reset", 1'b1, 16'h0000, 64, 0, 0, 1'b0, -1);
    do_fetch("after_reset_coef", 1'b0, 16'h0100, 16, 0, 0, 1'b0, -1);
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity();
    do_fetch("parity_bad", 1'b1, 16'h0000, 64, 0, 0, 1'b0, 5);
    do_fetch("parity_clear", 1'b1, 16'h0000, 64, 0, 0, 1'b0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_image_fetch();
    test_coef_sets();
    test_coef_wrap();
    test_rewind();
    test_start_while_busy();
    test_reset_mid_fetch();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
